// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer: fetches a word at pc, decodes it into issue
// fields, offers it to the execute units and advances pc on completion.
module cpu_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_2000,
  parameter logic [4:0]  HALT_OP  = 5'h1F
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  issue_op,
  output logic [4:0]  issue_rd,
  output logic [4:0]  issue_rs,
  output logic [4:0]  issue_rt,
  output logic [11:0] issue_L,
  output logic        issue_valid,
  input  logic        exec_done,
  input  logic        exec_err,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] pc,
  output logic [31:0] retired,
  output logic        halted,
  output logic        error
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_HALT   = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] retired_q;
  logic [31:0] ir_q;
  logic [4:0]  op_q, rd_q, rs_q, rt_q;
  logic [11:0] l_q;
  logic        req_q, valid_q, halted_q, error_q;

  logic [31:0] pc_d;
  logic        fault_d;

  always_comb begin
    pc_d    = br_taken ? br_target : (pc_q + 32'd4);
    fault_d = exec_err | (br_taken & (br_target[1:0] != 2'b00));
  end

  // req resets high so the first fetch is already requested when reset drops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      retired_q <= 32'd0;
      ir_q      <= 32'd0;
      op_q      <= 5'd0;
      rd_q      <= 5'd0;
      rs_q      <= 5'd0;
      rt_q      <= 5'd0;
      l_q       <= 12'd0;
      req_q     <= 1'b1;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_ack) begin
            ir_q    <= imem_rdata;
            req_q   <= 1'b0;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          op_q <= ir_q[31:27];
          rd_q <= ir_q[26:22];
          rs_q <= ir_q[21:17];
          rt_q <= ir_q[16:12];
          l_q  <= ir_q[11:0];
          if (ir_q[31:27] == HALT_OP) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            valid_q <= 1'b1;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (exec_done) begin
            valid_q <= 1'b0;
            if (fault_d) begin
              error_q <= 1'b1;
              state_q <= S_ERROR;
            end else begin
              pc_q      <= pc_d;
              retired_q <= retired_q + 32'd1;
              req_q     <= 1'b1;
              state_q   <= S_FETCH;
            end
          end
        end
        S_HALT, S_ERROR: ;
        default: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          error_q <= 1'b1;
          state_q <= S_ERROR;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign issue_op    = op_q;
  assign issue_rd    = rd_q;
  assign issue_rs    = rs_q;
  assign issue_rt    = rt_q;
  assign issue_L     = l_q;
  assign issue_valid = valid_q;
  assign pc          = pc_q;
  assign retired     = retired_q;
  assign halted      = halted_q;
  assign error       = error_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios then randomized traffic, checked
// against an instruction-level model of pc/retired/status.
module tb_cpu_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_2000;
  localparam logic [4:0]  HALT   = 5'h1F;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [4:0]  issue_op, issue_rd, issue_rs, issue_rt;
  logic [11:0] issue_L;
  logic        issue_valid;
  logic        exec_done, exec_err, br_taken;
  logic [31:0] br_target;
  logic [31:0] pc, retired;
  logic        halted, error;

  cpu_sequencer #(.RESET_PC(RST_PC), .HALT_OP(HALT)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .issue_op(issue_op), .issue_rd(issue_rd), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_L(issue_L), .issue_valid(issue_valid),
    .exec_done(exec_done), .exec_err(exec_err), .br_taken(br_taken), .br_target(br_target),
    .pc(pc), .retired(retired), .halted(halted), .error(error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Instruction-level model: where the sequencer should be in its life cycle.
  typedef enum {WAIT_WORD, DECODING, OFFERED, STOPPED} phase_t;
  phase_t      m_phase;
  logic [31:0] m_pc, m_ret, m_word;
  logic        m_halt, m_err;

  task automatic model_reset();
    m_phase = WAIT_WORD;
    m_pc    = RST_PC;
    m_ret   = 32'd0;
    m_word  = 32'd0;
    m_halt  = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic idle_inputs();
    imem_ack = 0; imem_rdata = 0; exec_done = 0; exec_err = 0; br_taken = 0; br_target = 0;
  endtask

  // Called at a negedge: compare outputs, apply inputs for the next edge, advance model.
  task automatic cyc(input logic a, input logic [31:0] word, input logic d, input logic e,
                     input logic bt, input logic [31:0] tgt);
    check("imem_req", imem_req, m_phase == WAIT_WORD);
    if (m_phase == WAIT_WORD) check("imem_addr", imem_addr, m_pc);
    check("issue_valid", issue_valid, m_phase == OFFERED);
    if (m_phase == OFFERED) begin
      check("issue_op", issue_op, m_word[31:27]);
      check("issue_rd", issue_rd, m_word[26:22]);
      check("issue_rs", issue_rs, m_word[21:17]);
      check("issue_rt", issue_rt, m_word[16:12]);
      check("issue_L", issue_L, m_word[11:0]);
    end
    check("req_and_valid", imem_req & issue_valid, 0);
    check("pc", pc, m_pc);
    check("retired", retired, m_ret);
    check("halted", halted, m_halt);
    check("error", error, m_err);

    imem_ack = a; imem_rdata = word; exec_done = d; exec_err = e; br_taken = bt; br_target = tgt;
    case (m_phase)
      WAIT_WORD: if (a) begin m_word = word; m_phase = DECODING; end
      DECODING: begin
        if (m_word[31:27] == HALT) begin m_halt = 1; m_phase = STOPPED; end
        else m_phase = OFFERED;
      end
      OFFERED: if (d) begin
        if (e || (bt && tgt[1:0] != 2'b00)) begin m_err = 1; m_phase = STOPPED; end
        else begin
          m_pc  = bt ? tgt : m_pc + 32'd4;
          m_ret = m_ret + 32'd1;
          m_phase = WAIT_WORD;
        end
      end
      default: ;
    endcase
    @(negedge clk);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock edge.
  task automatic reset_pulse();
    #2 reset = 1;
    idle_inputs();
    #1;
    check("rst_pc", pc, RST_PC);
    check("rst_retired", retired, 0);
    check("rst_valid", issue_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_error", error, 0);
    check("rst_issue_op", issue_op, 0);
    check("rst_issue_L", issue_L, 0);
    @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 7) == 0) w[31:27] = HALT;
    else if (w[31:27] == HALT) w[31:27] = 5'h00;
    return w;
  endfunction

  initial begin
    int stop_cnt;
    logic [31:0] tgt;
    reset = 1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("init_pc", pc, RST_PC);
    check("init_retired", retired, 0);
    reset = 0;

    // Basic instruction, same-cycle ack and done
    cyc(1, 32'h0844_6005, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("d_op", issue_op, 5'h01);
    check("d_rd", issue_rd, 5'd1);
    check("d_rs", issue_rs, 5'd2);
    check("d_rt", issue_rt, 5'd6);
    check("d_L", issue_L, 12'h005);
    check("d_valid", issue_valid, 1);
    cyc(0, 0, 1, 0, 0, 0);
    check("d_pc4", pc, 32'h2004);
    check("d_ret1", retired, 1);

    // Delayed ack, then a taken branch, then a misaligned branch
    quiet(3);
    cyc(1, 32'h0800_0000, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 32'h3000);
    check("d_br_addr", imem_addr, 32'h3000);
    cyc(1, 32'h1000_0000, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 32'h3002);
    check("d_misalign_err", error, 1);
    check("d_misalign_pc", pc, 32'h3000);
    quiet(3);
    reset_pulse();

    // Halt instruction with a spurious done while halted
    cyc(1, 32'hF800_0000, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    check("d_halted", halted, 1);
    check("d_halt_pc", pc, RST_PC);
    cyc(0, 0, 1, 0, 0, 0);
    quiet(2);
    reset_pulse();

    // Spurious done in fetch/decode, then exec_err; then reset during exec
    cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 32'h2222_2222, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    check("d_err", error, 1);
    check("d_err_ret", retired, 0);
    quiet(2);
    reset_pulse();
    cyc(1, 32'h0844_6005, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    reset_pulse();
    quiet(1);

    // Randomized traffic
    stop_cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      if (stop_cnt > 4 || $urandom_range(0, 299) == 0) begin
        reset_pulse();
        stop_cnt = 0;
      end else begin
        tgt = $urandom;
        if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
        cyc($urandom_range(0, 1) == 1, rand_word(), $urandom_range(0, 1) == 1,
            $urandom_range(0, 31) == 0, $urandom_range(0, 2) == 0, tgt);
        stop_cnt = (m_phase == STOPPED) ? stop_cnt + 1 : 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port imem_req, output, 1, fetch request.
REQ-004 SHALL have port imem_addr, output, 32, fetch address, equals pc while imem_req=1.
REQ-005 SHALL have port imem_ack, input, 1, fetch complete, imem_rdata valid same cycle.
REQ-006 SHALL have port imem_rdata, input, 32, fetched instruction word.
REQ-007 SHALL have ports issue_op (5), issue_rd (5), issue_rs (5), issue_rt (5), issue_L (12), all outputs, decoded fields of the held instruction.
REQ-008 SHALL have port issue_valid, output, 1, instruction offered to execute units.
REQ-009 SHALL have port exec_done, input, 1, execute complete; sampled only while issue_valid=1.
REQ-010 SHALL have ports exec_err (input, 1), br_taken (input, 1) and br_target (input, 32), qualified by exec_done.
REQ-011 SHALL have port pc, output, 32, address of the current instruction.
REQ-012 SHALL have port retired, output, 32, count of completed instructions.
REQ-013 SHALL have ports halted (output, 1) and error (output, 1), sticky status flags.
REQ-014 SHALL have parameters RESET_PC, default 32'h0000_2000, pc after reset; and HALT_OP, default 5'h1F, halt opcode.

Function
REQ-015 SHALL implement FSM states FETCH, DECODE, EXEC, HALT and ERROR.
REQ-016 In FETCH, SHALL assert imem_req with imem_addr=pc, held until imem_ack; on imem_ack SHALL latch imem_rdata into the instruction register and go to DECODE.
REQ-017 In DECODE (one cycle), SHALL register the fields: op=[31:27], rd=[26:22], rs=[21:17], rt=[16:12], L=[11:0].
REQ-018 From DECODE, SHALL go to HALT if op==HALT_OP, else to EXEC; a halt instruction is never issued.
REQ-019 In EXEC, SHALL hold issue_valid=1 with stable issue_* fields until exec_done=1.
REQ-020 On exec_done with exec_err=1, SHALL go to ERROR with pc and retired unchanged.
REQ-021 On exec_done with br_taken=1 and br_target[1:0]!=0, SHALL go to ERROR with pc unchanged.
REQ-022 Otherwise on exec_done, SHALL set pc to br_target if br_taken=1, else pc+4 (mod 2^32), increment retired (wrapping at 2^32), and go to FETCH.
REQ-023 The minimum instruction period SHALL be 3 cycles: FETCH with same-cycle ack, DECODE, and EXEC with same-cycle done.
REQ-024 HALT SHALL be absorbing; it SHALL set halted=1 and pc SHALL stay at the halt instruction address.
REQ-025 ERROR SHALL be absorbing; it SHALL set error=1. Only reset leaves HALT or ERROR.
REQ-026 imem_req and issue_valid SHALL never be asserted in the same cycle.
REQ-027 imem_ack outside FETCH and exec_done outside EXEC SHALL be ignored.

Reset
REQ-028 On reset, SHALL immediately set state=FETCH, pc=RESET_PC, retired=0, issue_valid=0, halted=0, error=0, and clear the instruction register and issue_*; imem_req SHALL rise in the first cycle after reset deasserts.
REQ-029 Reset asserted mid-fetch or mid-execute SHALL abort the transaction with no pc or retired update.

Verification
REQ-030 Release reset, ack the fetch at once with 32'h0844_6005 -> issue_op=5'h01, rd=1, rs=2, rt=6, L=12'h005, issue_valid=1; exec_done then gives pc=32'h2004, retired=1.
REQ-031 Delay imem_ack 3 cycles -> imem_req and imem_addr=32'h2000 held stable for the wait; no DECODE before the ack.
REQ-032 exec_done with br_taken=1 and br_target=32'h3000 -> next imem_addr=32'h3000; with br_target=32'h3002 -> error=1, pc unchanged, no further imem_req.
REQ-033 Fetch 32'hF800_0000 -> halted=1, issue_valid never asserted, pc stays at the halt instruction address, retired unchanged.
REQ-034 Assert reset during EXEC -> all outputs return to reset values within the same cycle; operation resumes at RESET_PC.
REQ-035 Spurious exec_done pulses during FETCH and DECODE, exec_err=1 in EXEC -> spurious pulses ignored; exec_err gives error=1 and retired unchanged.
